// File: rtl/uart_rx_frame_parser_if.sv
// Byte-stream bundle between the UART receiver, the frame parser and its consumer.
interface uart_rx_frame_parser_if;
  logic       i_RX_DV;
  logic [7:0] i_RX_Byte;
  logic       o_Data_Valid;
  logic [7:0] o_Data_Byte;
  logic       o_Data_Last;
  logic       i_Data_Ready;
  logic       o_Frame_Good;
  logic       o_Frame_Err;
  logic       o_Overrun;
  logic       o_Busy;

  modport slave (
    input  i_RX_DV, i_RX_Byte, i_Data_Ready,
    output o_Data_Valid, o_Data_Byte, o_Data_Last,
           o_Frame_Good, o_Frame_Err, o_Overrun, o_Busy
  );

  modport master (
    output i_RX_DV, i_RX_Byte, i_Data_Ready,
    input  o_Data_Valid, o_Data_Byte, o_Data_Last,
           o_Frame_Good, o_Frame_Err, o_Overrun, o_Busy
  );
endinterface

// File: rtl/uart_rx_frame_parser.sv
// Sync/length/payload/XOR-checksum frame parser; releases checked payloads on a valid/ready stream.
// Define PARSER_TIMEOUT_EN to abort partial frames after TIMEOUT_CLKS idle clocks.
module uart_rx_frame_parser #(
  parameter logic [7:0] SYNC_BYTE    = 8'hA5,
  parameter int         MAX_LEN      = 16,
  parameter int         TIMEOUT_CLKS = 1000
) (
  input logic                   i_Clock,
  input logic                   i_Rst_n,
  uart_rx_frame_parser_if.slave bus
);
  localparam int         LW        = $clog2(MAX_LEN + 1);
  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  typedef enum logic [2:0] {HUNT, GET_LEN, GET_PAYLOAD, GET_CSUM, DRAIN} state_t;

  state_t        state_q, state_d;
  logic [LW-1:0] len_q, wr_idx_q, rd_idx_q;
  logic [7:0]    acc_q;
  logic [7:0]    buf_mem [MAX_LEN];
  logic          good_q, err_q, ovr_q;
  logic          good_d, err_d, ovr_d;
  logic          rx_dv, hs, wr_last, rd_last, len_bad, timeout_hit, data_vld;
  logic [7:0]    rx_byte;

  assign rx_dv   = bus.i_RX_DV;
  assign rx_byte = bus.i_RX_Byte;
  assign data_vld = (state_q == DRAIN);
  assign hs      = data_vld && bus.i_Data_Ready;
  assign wr_last = (wr_idx_q == len_q - LW'(1));
  assign rd_last = (rd_idx_q == len_q - LW'(1));
  assign len_bad = (rx_byte == 8'h00) || (rx_byte > MAX_LEN_B);

`ifdef PARSER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CLKS + 1);
  logic [TW-1:0] to_cnt_q;
  logic          in_frame;

  assign in_frame = (state_q == GET_LEN) || (state_q == GET_PAYLOAD) || (state_q == GET_CSUM);
  // An arriving byte beats a timeout landing in the same cycle.
  assign timeout_hit = in_frame && !rx_dv && (to_cnt_q == TW'(TIMEOUT_CLKS - 1));

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n)                  to_cnt_q <= '0;
    else if (rx_dv || !in_frame)   to_cnt_q <= '0;
    else                           to_cnt_q <= to_cnt_q + TW'(1);
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    good_d  = 1'b0;
    err_d   = 1'b0;
    ovr_d   = 1'b0;
    case (state_q)
      HUNT: if (rx_dv && rx_byte == SYNC_BYTE) state_d = GET_LEN;
      GET_LEN: begin
        // A repeated sync byte is just a length here, never a resync.
        if (rx_dv) begin
          if (len_bad) begin
            err_d   = 1'b1;
            state_d = HUNT;
          end else begin
            state_d = GET_PAYLOAD;
          end
        end
      end
      GET_PAYLOAD: if (rx_dv && wr_last) state_d = GET_CSUM;
      GET_CSUM: begin
        if (rx_dv) begin
          if (rx_byte == acc_q) begin
            good_d  = 1'b1;
            state_d = DRAIN;
          end else begin
            err_d   = 1'b1;
            state_d = HUNT;
          end
        end
      end
      DRAIN: begin
        ovr_d = rx_dv;
        if (hs && rd_last) state_d = HUNT;
      end
      default: state_d = HUNT;
    endcase
    if (timeout_hit) begin
      err_d   = 1'b1;
      state_d = HUNT;
    end
  end

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q  <= HUNT;
      len_q    <= '0;
      wr_idx_q <= '0;
      rd_idx_q <= '0;
      acc_q    <= '0;
      good_q   <= 1'b0;
      err_q    <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      good_q  <= good_d;
      err_q   <= err_d;
      ovr_q   <= ovr_d;
      case (state_q)
        GET_LEN: if (rx_dv && !len_bad) begin
          len_q    <= rx_byte[LW-1:0];
          acc_q    <= rx_byte;
          wr_idx_q <= '0;
        end
        GET_PAYLOAD: if (rx_dv) begin
          acc_q    <= acc_q ^ rx_byte;
          wr_idx_q <= wr_idx_q + LW'(1);
        end
        GET_CSUM: rd_idx_q <= '0;
        DRAIN:    if (hs) rd_idx_q <= rd_idx_q + LW'(1);
        default: ;
      endcase
    end
  end

  // Payload storage needs no reset; it is only read after being written.
  always_ff @(posedge i_Clock) begin
    if (state_q == GET_PAYLOAD && rx_dv) buf_mem[wr_idx_q] <= rx_byte;
  end

  assign bus.o_Data_Valid = data_vld;
  assign bus.o_Data_Byte  = data_vld ? buf_mem[rd_idx_q] : 8'h00;
  assign bus.o_Data_Last  = data_vld && rd_last;
  assign bus.o_Frame_Good = good_q;
  assign bus.o_Frame_Err  = err_q;
  assign bus.o_Overrun    = ovr_q;
  assign bus.o_Busy       = (state_q != HUNT);
endmodule

// File: tb/tb_uart_rx_frame_parser.sv
// Self-checking bench: directed vector table, corner sequences and randomized frames vs a frame-level model.
module tb_uart_rx_frame_parser;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_rx_frame_parser_if bus();
  uart_rx_frame_parser #(.SYNC_BYTE(8'hA5), .MAX_LEN(16), .TIMEOUT_CLKS(50)) dut (
    .i_Clock(clk), .i_Rst_n(rst_n), .bus(bus)
  );

  int n_checks = 0;
  int n_err    = 0;
  int good_cnt = 0, err_cnt = 0, ovr_cnt = 0;
  logic [8:0] got_q[$];
  logic [8:0] exp_q[$];
  logic rand_rdy = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: counts pulses, logs handshakes, checks pulse exclusivity and backpressure hold.
  logic pv = 1'b0, pr = 1'b0, pl = 1'b0;
  logic [7:0] pb = 8'h00;
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.o_Frame_Good || bus.o_Frame_Err || bus.o_Overrun)
        chk("pulse_exclusive", 32'(bus.o_Frame_Good) + 32'(bus.o_Frame_Err) + 32'(bus.o_Overrun), 1);
      if (pv && !pr) begin
        chk("hold_valid", 32'(bus.o_Data_Valid), 1);
        chk("hold_byte", 32'(bus.o_Data_Byte), 32'(pb));
        chk("hold_last", 32'(bus.o_Data_Last), 32'(pl));
      end
      good_cnt += int'(bus.o_Frame_Good);
      err_cnt  += int'(bus.o_Frame_Err);
      ovr_cnt  += int'(bus.o_Overrun);
      if (bus.o_Data_Valid && bus.i_Data_Ready) got_q.push_back({bus.o_Data_Last, bus.o_Data_Byte});
    end
    pv = bus.o_Data_Valid; pr = bus.i_Data_Ready; pb = bus.o_Data_Byte; pl = bus.o_Data_Last;
  end

  always @(posedge clk) if (rand_rdy) #1 bus.i_Data_Ready = 1'($urandom_range(0, 1));

  task automatic send_byte(input logic [7:0] b, input int gap);
    @(posedge clk); #1;
    bus.i_RX_DV = 1'b1; bus.i_RX_Byte = b;
    @(posedge clk); #1;
    bus.i_RX_DV = 1'b0;
    repeat (gap) @(posedge clk);
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    while (bus.o_Busy && k < 400) begin @(negedge clk); k++; end
    chk(name, 32'(bus.o_Busy), 0);
  endtask

  typedef struct {
    int n; logic [7:0] b[8]; int good; int err; int nout; logic [7:0] o[3];
  } vec_t;
  vec_t vt[6];

  initial begin
    int g0, e0, o0, t0;
    logic [7:0] pl_b[$];
    logic [7:0] cs;
    bus.i_RX_DV = 1'b0; bus.i_RX_Byte = 8'h00; bus.i_Data_Ready = 1'b1;

    vt[0] = '{6, '{8'hA5,8'h03,8'h11,8'h22,8'h33,8'h03,8'h00,8'h00}, 1, 0, 3, '{8'h11,8'h22,8'h33}};
    vt[1] = '{6, '{8'hA5,8'h03,8'h11,8'h22,8'h33,8'h04,8'h00,8'h00}, 0, 1, 0, '{8'h00,8'h00,8'h00}};
    vt[2] = '{4, '{8'hA5,8'h01,8'h5A,8'h5B,8'h00,8'h00,8'h00,8'h00}, 1, 0, 1, '{8'h5A,8'h00,8'h00}};
    vt[3] = '{2, '{8'hA5,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00}, 0, 1, 0, '{8'h00,8'h00,8'h00}};
    vt[4] = '{2, '{8'hA5,8'h11,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00}, 0, 1, 0, '{8'h00,8'h00,8'h00}};
    vt[5] = '{8, '{8'h00,8'hFF,8'h7E,8'hA5,8'h02,8'hAA,8'hBB,8'h13}, 1, 0, 2, '{8'hAA,8'hBB,8'h00}};

    #2;
    chk("rst_valid", 32'(bus.o_Data_Valid), 0);
    chk("rst_busy", 32'(bus.o_Busy), 0);
    chk("rst_pulses", {29'd0, bus.o_Frame_Good, bus.o_Frame_Err, bus.o_Overrun}, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Latency: good pulse and first byte one clock after the checksum byte.
    got_q.delete();
    foreach (vt[0].b[j]) if (j < 5) send_byte(vt[0].b[j], 0);
    send_byte(8'h03, 0);
    @(negedge clk);
    chk("lat_good", 32'(bus.o_Frame_Good), 1);
    chk("lat_valid", 32'(bus.o_Data_Valid), 1);
    chk("lat_byte0", 32'(bus.o_Data_Byte), 32'h11);
    @(negedge clk);
    chk("lat_byte1", 32'(bus.o_Data_Byte), 32'h22);
    @(negedge clk);
    chk("lat_byte2", 32'(bus.o_Data_Byte), 32'h33);
    chk("lat_last", 32'(bus.o_Data_Last), 1);
    @(negedge clk);
    chk("lat_done", 32'(bus.o_Data_Valid), 0);
    chk("lat_idle", 32'(bus.o_Busy), 0);

    for (int i = 0; i < 6; i++) begin
      g0 = good_cnt; e0 = err_cnt; o0 = ovr_cnt;
      got_q.delete();
      for (int j = 0; j < vt[i].n; j++) send_byte(vt[i].b[j], 1);
      repeat (12) @(negedge clk);
      chk($sformatf("v%0d_good", i), 32'(good_cnt - g0), 32'(vt[i].good));
      chk($sformatf("v%0d_err", i), 32'(err_cnt - e0), 32'(vt[i].err));
      chk($sformatf("v%0d_ovr", i), 32'(ovr_cnt - o0), 0);
      chk($sformatf("v%0d_nout", i), 32'(got_q.size()), 32'(vt[i].nout));
      for (int j = 0; j < vt[i].nout && j < got_q.size(); j++)
        chk($sformatf("v%0d_out%0d", i, j), 32'(got_q[j]), {23'd0, (j == vt[i].nout - 1), vt[i].o[j]});
      chk($sformatf("v%0d_busy", i), 32'(bus.o_Busy), 0);
    end

    // Maximum length frame.
    got_q.delete(); g0 = good_cnt;
    cs = 8'h10;
    send_byte(8'hA5, 0); send_byte(8'h10, 0);
    for (int j = 0; j < 16; j++) begin
      pl_b.push_back(8'($urandom)); cs ^= pl_b[j]; send_byte(pl_b[j], 0);
    end
    send_byte(cs, 0);
    repeat (20) @(negedge clk);
    chk("max_good", 32'(good_cnt - g0), 1);
    chk("max_nout", 32'(got_q.size()), 16);
    for (int j = 0; j < 16 && j < got_q.size(); j++)
      chk($sformatf("max_out%0d", j), 32'(got_q[j]), {23'd0, (j == 15), pl_b[j]});

    // Backpressure with an overrun byte mid-drain.
    got_q.delete(); o0 = ovr_cnt;
    bus.i_Data_Ready = 1'b0;
    foreach (vt[0].b[j]) if (j < 6) send_byte(vt[0].b[j], 0);
    repeat (20) @(negedge clk);
    chk("bp_valid", 32'(bus.o_Data_Valid), 1);
    chk("bp_byte", 32'(bus.o_Data_Byte), 32'h11);
    send_byte(8'hA5, 0);
    @(negedge clk);
    chk("ovr_pulse", 32'(bus.o_Overrun), 1);
    chk("ovr_hold", 32'(bus.o_Data_Byte), 32'h11);
    bus.i_Data_Ready = 1'b1;
    repeat (6) @(negedge clk);
    chk("ovr_cnt", 32'(ovr_cnt - o0), 1);
    chk("bp_nout", 32'(got_q.size()), 3);
    if (got_q.size() == 3) chk("bp_data", {8'd0, got_q[0], got_q[1], got_q[2]}, {8'd0, 9'h011, 9'h022, 9'h133});
    chk("bp_idle", 32'(bus.o_Busy), 0);

    // Reset mid-frame.
    g0 = good_cnt; e0 = err_cnt; o0 = ovr_cnt;
    send_byte(8'hA5, 0); send_byte(8'h02, 0); send_byte(8'hAA, 0);
    chk("pre_rst_busy", 32'(bus.o_Busy), 1);
    rst_n = 1'b0; #1;
    chk("mid_rst_busy", 32'(bus.o_Busy), 0);
    chk("mid_rst_out", {28'd0, bus.o_Data_Valid, bus.o_Data_Last, bus.o_Frame_Good, bus.o_Frame_Err}, 0);
    @(negedge clk); rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("post_rst_pulses", 32'(good_cnt - g0 + err_cnt - e0 + ovr_cnt - o0), 0);

    // Partial frame followed by silence.
    e0 = err_cnt;
    send_byte(8'hA5, 0); send_byte(8'h03, 0); send_byte(8'h11, 0);
    t0 = 0;
    while (err_cnt == e0 && t0 < 70) begin @(negedge clk); t0++; end
`ifdef PARSER_TIMEOUT_EN
    chk("to_err", 32'(err_cnt - e0), 1);
    chk("to_window", 32'(t0 >= 45 && t0 <= 55), 1);
    @(negedge clk);
    chk("to_busy", 32'(bus.o_Busy), 0);
`else
    chk("no_to_err", 32'(err_cnt - e0), 0);
    chk("no_to_busy", 32'(bus.o_Busy), 1);
`endif
    rst_n = 1'b0; @(negedge clk); rst_n = 1'b1;

    // Randomized frames against a frame-level model.
    got_q.delete(); exp_q.delete();
    g0 = good_cnt; e0 = err_cnt; o0 = ovr_cnt;
    begin
      int eg, ee, kind, len;
      logic [7:0] b;
      eg = 0; ee = 0;
      rand_rdy = 1'b1;
      for (int f = 0; f < 40; f++) begin
        kind = $urandom_range(0, 3);
        if (kind == 3) begin
          for (int j = 0; j < $urandom_range(1, 3); j++) begin
            b = 8'($urandom); if (b == 8'hA5) b = 8'h5A;
            send_byte(b, $urandom_range(0, 2));
          end
        end else if (kind == 2) begin
          len = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(17, 255);
          send_byte(8'hA5, 0); send_byte(8'(len), 0); ee++;
        end else begin
          len = $urandom_range(1, 16);
          cs = 8'(len);
          send_byte(8'hA5, $urandom_range(0, 2)); send_byte(8'(len), $urandom_range(0, 2));
          for (int j = 0; j < len; j++) begin
            b = 8'($urandom); cs ^= b;
            if (kind == 0) exp_q.push_back({(j == len - 1), b});
            send_byte(b, $urandom_range(0, 3));
          end
          if (kind == 0) begin send_byte(cs, 0); eg++; end
          else begin send_byte(cs ^ 8'(1 << $urandom_range(0, 7)), 0); ee++; end
        end
        wait_idle("rnd_idle");
      end
      rand_rdy = 1'b0;
      @(posedge clk); #1 bus.i_Data_Ready = 1'b1;
      repeat (4) @(negedge clk);
      chk("rnd_good", 32'(good_cnt - g0), 32'(eg));
      chk("rnd_err", 32'(err_cnt - e0), 32'(ee));
      chk("rnd_ovr", 32'(ovr_cnt - o0), 0);
      chk("rnd_nout", 32'(got_q.size()), 32'(exp_q.size()));
      for (int j = 0; j < exp_q.size() && j < got_q.size(); j++)
        chk($sformatf("rnd_out%0d", j), 32'(got_q[j]), 32'(exp_q[j]));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
